// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-strobe bundle for mem_access_ctrl.
// slave = the controller; master = control unit plus memory array.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_data_in, mem_read, mem_write
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_data_in, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer for a combinational memory array:
// setup cycle, ACCESS_CYCLES strobe cycles, hold cycle. MEM_ADDR_CHECK_EN adds range rejection.
module mem_access_ctrl #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int MEM_DEPTH     = 512,
  parameter int ACCESS_CYCLES = 1
) (
  input logic              clk,
  input logic              clr,
  mem_access_ctrl_if.slave bus
);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             accept;
  logic             addr_oor;

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15 || MEM_DEPTH < 1 || DATA_W < 1)
  begin : g_bad_param
    $error("mem_access_ctrl: parameter out of range");
  end

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && (state == IDLE);

`ifdef MEM_ADDR_CHECK_EN
  assign addr_oor = {1'b0, bus.req_addr} >= (ADDR_W+1)'(MEM_DEPTH);
`else
  assign addr_oor    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = addr_oor ? HOLD : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data only move on accept, so they are stable around every strobe.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.mem_address <= '0;
      bus.mem_data_in <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      cnt             <= '0;
      we_q            <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
      bus.rsp_err     <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
      bus.rsp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            bus.mem_address <= bus.req_addr;
            if (bus.req_we) bus.mem_data_in <= bus.req_wdata;
            we_q <= bus.req_we;
            if (addr_oor) begin
              bus.rsp_valid <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
              bus.rsp_err   <= 1'b1;
`endif
            end
          end
        end
        SETUP: begin
          cnt           <= CNT_W'(ACCESS_CYCLES - 1);
          bus.mem_read  <= !we_q;
          bus.mem_write <= we_q;
        end
        ACCESS: begin
          if (cnt == '0) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.rsp_valid <= 1'b1;
            if (!we_q) bus.rsp_rdata <= bus.mem_data_out;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: ACCESS_CYCLES=1 and =3 instances, behavioural memories, response scoreboards.
module tb_mem_access_ctrl;
  localparam int DW = 32, AW = 32, DEPTH = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, preload, sel;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;

  mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .ACCESS_CYCLES(1))
    dut_a (.clk(clk), .clr(clr), .bus(ifa));
  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .ACCESS_CYCLES(3))
    dut_b (.clk(clk), .clr(clr), .bus(ifb));

  assign ifa.req_valid = req_valid & ~sel;
  assign ifb.req_valid = req_valid & sel;
  assign ifa.req_we    = req_we;
  assign ifb.req_we    = req_we;
  assign ifa.req_addr  = req_addr;
  assign ifb.req_addr  = req_addr;
  assign ifa.req_wdata = req_wdata;
  assign ifb.req_wdata = req_wdata;

  // Combinational memories; they share clr, so a write strobe coincident with clr does not commit.
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  assign ifa.mem_data_out = (ifa.mem_address < DEPTH) ? mem_a[ifa.mem_address[8:0]] : 32'hDEAD_BEEF;
  assign ifb.mem_data_out = (ifb.mem_address < DEPTH) ? mem_b[ifb.mem_address[8:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_a[43] <= 32'h2; mem_a[95] <= 32'hD; mem_a[51] <= 32'h7;
      mem_b[43] <= 32'h2; mem_b[95] <= 32'hD; mem_b[51] <= 32'h7;
    end else begin
      if (ifa.mem_write && !clr && ifa.mem_address < DEPTH) mem_a[ifa.mem_address[8:0]] <= ifa.mem_data_in;
      if (ifb.mem_write && !clr && ifb.mem_address < DEPTH) mem_b[ifb.mem_address[8:0]] <= ifb.mem_data_in;
    end
  end

  // Observation mux onto the instance under test.
  logic        o_ready, o_rsp, o_read, o_write;
  logic [31:0] o_addr, o_rdata;
  assign o_ready = sel ? ifb.req_ready   : ifa.req_ready;
  assign o_rsp   = sel ? ifb.rsp_valid   : ifa.rsp_valid;
  assign o_read  = sel ? ifb.mem_read    : ifa.mem_read;
  assign o_write = sel ? ifb.mem_write   : ifa.mem_write;
  assign o_addr  = sel ? ifb.mem_address : ifa.mem_address;
  assign o_rdata = sel ? ifb.rsp_rdata   : ifa.rsp_rdata;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        q_a[$], q_b[$];
  logic [31:0] last_a, last_b;
  int          n_chk = 0, n_fail = 0;

  function automatic logic [31:0] model_rd(input bit s, input logic [31:0] a);
    if (a >= DEPTH) return 32'hDEAD_BEEF;
    return s ? mem_b[a[8:0]] : mem_a[a[8:0]];
  endfunction

  task automatic push_exp(input bit s, input logic we, input logic [31:0] a);
    exp_t e;
`ifdef MEM_ADDR_CHECK_EN
    e.err = (a >= DEPTH);
`else
    e.err = 1'b0;
`endif
    e.rdata = s ? last_b : last_a;
    if (!we && !e.err) e.rdata = model_rd(s, a);
    if (s) begin last_b = e.rdata; q_b.push_back(e); end
    else   begin last_a = e.rdata; q_a.push_back(e); end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifa.rsp_valid) begin
      n_chk++;
      if (q_a.size() == 0) begin
        n_fail++; $display("FAIL rsp_a_unexpected: got rdata=%h err=%b, required no response", ifa.rsp_rdata, ifa.rsp_err);
      end else begin
        e = q_a.pop_front();
        if (ifa.rsp_rdata !== e.rdata || ifa.rsp_err !== e.err) begin
          n_fail++; $display("FAIL rsp_a: got rdata=%h err=%b, required rdata=%h err=%b", ifa.rsp_rdata, ifa.rsp_err, e.rdata, e.err);
        end
      end
    end
    if (ifb.rsp_valid) begin
      n_chk++;
      if (q_b.size() == 0) begin
        n_fail++; $display("FAIL rsp_b_unexpected: got rdata=%h err=%b, required no response", ifb.rsp_rdata, ifb.rsp_err);
      end else begin
        e = q_b.pop_front();
        if (ifb.rsp_rdata !== e.rdata || ifb.rsp_err !== e.err) begin
          n_fail++; $display("FAIL rsp_b: got rdata=%h err=%b, required rdata=%h err=%b", ifb.rsp_rdata, ifb.rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  // Issues one request on the selected instance and records what happens over win cycles.
  task automatic run_txn(input bit s, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input int win, output int rd_n, output int wr_n, output int rd_first,
                         output int rsp_at, output int rdy_at, output int addr_bad);
    int t;
    sel = s; rd_n = 0; wr_n = 0; rd_first = 0; rsp_at = 0; rdy_at = 0; addr_bad = 0;
    t = 0;
    while (!o_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_chk++; n_fail++; $display("FAIL ready_timeout: got req_ready=0 for 50 cycles, required 1");
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    push_exp(s, we, a);
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      if (o_read) begin rd_n++; if (rd_first == 0) rd_first = c; end
      if (o_write) wr_n++;
      if (o_read && o_write) addr_bad++;
      if (rdy_at == 0 && o_addr !== a) addr_bad++;
      if (o_rsp && rsp_at == 0) rsp_at = c;
      if (o_ready && rdy_at == 0) rdy_at = c;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; preload = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    last_a = '0; last_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({ifa.req_ready, ifa.rsp_valid, ifa.rsp_err, ifa.mem_read, ifa.mem_write, ifa.rsp_rdata, ifa.mem_address, ifa.mem_data_in}
        !== {1'b1, 4'b0, 96'h0}) begin
      n_fail++; $display("FAIL reset_a: got ready=%b vld=%b err=%b rd=%b wr=%b rdata=%h addr=%h din=%h, required 1,0,0,0,0,0,0,0",
        ifa.req_ready, ifa.rsp_valid, ifa.rsp_err, ifa.mem_read, ifa.mem_write, ifa.rsp_rdata, ifa.mem_address, ifa.mem_data_in);
    end
    n_chk++;
    if ({ifb.req_ready, ifb.rsp_valid, ifb.rsp_err, ifb.mem_read, ifb.mem_write, ifb.rsp_rdata, ifb.mem_address, ifb.mem_data_in}
        !== {1'b1, 4'b0, 96'h0}) begin
      n_fail++; $display("FAIL reset_b: got ready=%b vld=%b err=%b rd=%b wr=%b rdata=%h addr=%h din=%h, required 1,0,0,0,0,0,0,0",
        ifb.req_ready, ifb.rsp_valid, ifb.rsp_err, ifb.mem_read, ifb.mem_write, ifb.rsp_rdata, ifb.mem_address, ifb.mem_data_in);
    end
    preload = 1'b0; clr = 1'b0;
  endtask

  task automatic test_load();
    int rd_n, wr_n, rd_first, rsp_at, rdy_at, bad;
    run_txn(0, 1'b0, 32'd43, 32'h0, 8, rd_n, wr_n, rd_first, rsp_at, rdy_at, bad);
    n_chk++; if (rd_n !== 1)    begin n_fail++; $display("FAIL load_read_cycles: got %0d, required 1", rd_n); end
    n_chk++; if (wr_n !== 0)    begin n_fail++; $display("FAIL load_write_cycles: got %0d, required 0", wr_n); end
    n_chk++; if (rd_first !== 2) begin n_fail++; $display("FAIL load_read_cycle: got %0d, required 2", rd_first); end
    n_chk++; if (rsp_at !== 3)  begin n_fail++; $display("FAIL load_rsp_cycle: got %0d, required 3", rsp_at); end
    n_chk++; if (rdy_at !== 4)  begin n_fail++; $display("FAIL load_ready_cycle: got %0d, required 4", rdy_at); end
    n_chk++; if (bad !== 0)     begin n_fail++; $display("FAIL load_addr_stable: got %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_store_load();
    int rd_n, wr_n, rd_first, rsp_at, rdy_at, bad;
    run_txn(0, 1'b1, 32'd87, 32'h43, 8, rd_n, wr_n, rd_first, rsp_at, rdy_at, bad);
    n_chk++; if (wr_n !== 1)   begin n_fail++; $display("FAIL store_write_cycles: got %0d, required 1", wr_n); end
    n_chk++; if (rd_n !== 0)   begin n_fail++; $display("FAIL store_read_cycles: got %0d, required 0", rd_n); end
    n_chk++; if (rsp_at !== 3) begin n_fail++; $display("FAIL store_rsp_cycle: got %0d, required 3", rsp_at); end
    n_chk++; if (bad !== 0)    begin n_fail++; $display("FAIL store_addr_stable: got %0d bad cycles, required 0", bad); end
    n_chk++; if (o_rdata !== 32'h2) begin n_fail++; $display("FAIL store_rdata_kept: got %h, required 00000002", o_rdata); end
    run_txn(0, 1'b0, 32'd87, 32'h0, 8, rd_n, wr_n, rd_first, rsp_at, rdy_at, bad);
    n_chk++; if (rsp_at !== 3) begin n_fail++; $display("FAIL reload_rsp_cycle: got %0d, required 3", rsp_at); end
  endtask

  task automatic test_access_cycles();
    int rd_n, wr_n, rd_first, rsp_at, rdy_at, bad;
    run_txn(1, 1'b0, 32'd95, 32'h0, 10, rd_n, wr_n, rd_first, rsp_at, rdy_at, bad);
    n_chk++; if (rd_n !== 3)     begin n_fail++; $display("FAIL ac3_read_cycles: got %0d, required 3", rd_n); end
    n_chk++; if (rd_first !== 2) begin n_fail++; $display("FAIL ac3_read_first: got %0d, required 2", rd_first); end
    n_chk++; if (rsp_at !== 5)   begin n_fail++; $display("FAIL ac3_rsp_cycle: got %0d, required 5", rsp_at); end
    n_chk++; if (rdy_at !== 6)   begin n_fail++; $display("FAIL ac3_ready_cycle: got %0d, required 6", rdy_at); end
    n_chk++; if (bad !== 0)      begin n_fail++; $display("FAIL ac3_addr_stable: got %0d bad cycles, required 0", bad); end
    sel = 1'b0;
  endtask

  task automatic test_clr_abort();
    int rd_n, wr_n, rd_first, rsp_at, rdy_at, bad;
    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd51; req_wdata = 32'h99;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);                              // SETUP
    @(negedge clk);                              // ACCESS
    n_chk++; if (ifa.mem_write !== 1'b1) begin n_fail++; $display("FAIL abort_strobe_before: got %b, required 1", ifa.mem_write); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; last_a = '0;
    n_chk++;
    if ({ifa.mem_read, ifa.mem_write, ifa.req_ready, ifa.rsp_valid, ifa.rsp_rdata} !== {4'b0010, 32'h0}) begin
      n_fail++; $display("FAIL abort_state: got rd=%b wr=%b ready=%b vld=%b rdata=%h, required 0,0,1,0,0",
        ifa.mem_read, ifa.mem_write, ifa.req_ready, ifa.rsp_valid, ifa.rsp_rdata);
    end
    repeat (3) @(negedge clk);
    run_txn(0, 1'b0, 32'd51, 32'h0, 8, rd_n, wr_n, rd_first, rsp_at, rdy_at, bad);
    n_chk++; if (rsp_at !== 3) begin n_fail++; $display("FAIL abort_reload_rsp: got %0d, required 3", rsp_at); end
  endtask

  task automatic test_back_to_back();
    int acc[4];
    int n_acc = 0, bad = 0;
    logic [31:0] cur = '0;
    sel = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ifa.req_ready) begin
        if (n_acc == 4) begin req_valid = 1'b0; break; end
        req_valid = 1'b1; req_we = 1'b0;
        cur = n_acc[0] ? 32'd95 : 32'd43;
        req_addr = cur;
        push_exp(0, 1'b0, cur);
        acc[n_acc] = c; n_acc++;
      end else begin
        req_addr = 32'd300 + 32'(c);
        if (ifa.mem_address !== cur) bad++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_chk++; if (n_acc !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d, required 4", n_acc); end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (acc[i] - acc[i-1] !== 4) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d, required 4", i, acc[i] - acc[i-1]); end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_addr_hold: got %0d bad cycles, required 0", bad); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_addr_range();
    int rd_n, wr_n, rd_first, rsp_at, rdy_at, bad;
    run_txn(0, 1'b0, 32'd600, 32'h0, 8, rd_n, wr_n, rd_first, rsp_at, rdy_at, bad);
`ifdef MEM_ADDR_CHECK_EN
    n_chk++; if (rd_n !== 0)   begin n_fail++; $display("FAIL oor_read_cycles: got %0d, required 0", rd_n); end
    n_chk++; if (rsp_at !== 1) begin n_fail++; $display("FAIL oor_rsp_cycle: got %0d, required 1", rsp_at); end
    n_chk++; if (rdy_at !== 2) begin n_fail++; $display("FAIL oor_ready_cycle: got %0d, required 2", rdy_at); end
`else
    n_chk++; if (rd_n !== 1)   begin n_fail++; $display("FAIL oor_read_cycles: got %0d, required 1", rd_n); end
    n_chk++; if (rsp_at !== 3) begin n_fail++; $display("FAIL oor_rsp_cycle: got %0d, required 3", rsp_at); end
    n_chk++; if (bad !== 0)    begin n_fail++; $display("FAIL oor_addr_passed: got %0d bad cycles, required 0", bad); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_load();
    test_access_cycles();
    test_clr_abort();
    test_back_to_back();
    test_addr_range();
    repeat (4) @(negedge clk);
    n_chk++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
